// File: rtl/rr_mux_sel.sv
// rr_mux_sel
// Round-robin 4-way selector feeding mux4_1. Each cycle it picks one
// requesting channel, starting the search at a rotating priority pointer,
// and registers the winner's payload together with its 2-bit index.
// The registered index drives mux4_1 direction_i, so it is glitch-free.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   data0_i..3_i per-channel payload (DATA_W bits)
//   valid_i      per-channel request, bit n belongs to datan_i
//   ready_o      per-channel accept, one-hot or zero
//   data_o       registered selected payload
//   direction_o  registered index of the channel held in data_o
//   valid_o      output slot holds a word
//   ready_i      downstream accepts the word
module rr_mux_sel #(
  parameter int DATA_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data0_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [DATA_W-1:0] data3_i,
  input  logic [3:0]        valid_i,
  output logic [3:0]        ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        direction_o,
  output logic              valid_o,
  input  logic              ready_i
);

  logic [1:0]        ptr_r;
  logic              valid_r;
  logic [DATA_W-1:0] data_r;
  logic [1:0]        dir_r;

  logic              free_s;
  logic              any_s;
  logic [1:0]        grant_idx_s;
  logic              load_s;
  logic [DATA_W-1:0] grant_data_s;

  // Slot can take a new word when empty or when the current word leaves now.
  assign free_s = !valid_r || ready_i;

  // Rotating priority search: first requester at ptr, ptr+1, ptr+2, ptr+3.
  // The 2-bit index wraps naturally modulo 4.
  always_comb begin
    logic [1:0] idx_v;
    any_s       = 1'b0;
    grant_idx_s = 2'b00;
    idx_v       = 2'b00;
    for (int k = 0; k < 4; k++) begin
      idx_v = ptr_r + 2'(k);
      if (!any_s && valid_i[idx_v]) begin
        any_s       = 1'b1;
        grant_idx_s = idx_v;
      end else begin
        any_s       = any_s;
      end
    end
  end

  // A transfer happens only out of reset, with a free slot and a requester.
  assign load_s = rst_ni && free_s && any_s;

  // One-hot accept for the winner; gated by rst_ni so it is zero in reset.
  always_comb begin
    ready_o = 4'b0000;
    if (load_s) begin
      ready_o[grant_idx_s] = 1'b1;
    end else begin
      ready_o = 4'b0000;
    end
  end

  // Payload select for the winning channel.
  always_comb begin
    grant_data_s = '0;
    case (grant_idx_s)
      2'd0:    grant_data_s = data0_i;
      2'd1:    grant_data_s = data1_i;
      2'd2:    grant_data_s = data2_i;
      2'd3:    grant_data_s = data3_i;
      default: grant_data_s = '0;
    endcase
  end

  // Output slot and priority pointer. Payload and index load together so the
  // data/direction pairing can never split.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      dir_r   <= 2'b00;
      ptr_r   <= 2'b00;
    end else if (load_s) begin
      valid_r <= 1'b1;
      data_r  <= grant_data_s;
      dir_r   <= grant_idx_s;
      ptr_r   <= grant_idx_s + 2'd1;
    end else if (free_s) begin
      valid_r <= 1'b0;
    end
  end

  assign valid_o     = valid_r;
  assign data_o      = data_r;
  assign direction_o = dir_r;

endmodule

// File: tb/tb_rr_mux_sel.sv
// Directed bench for rr_mux_sel: reset, a vector table covering single
// request, round-robin, backpressure and wrap, a behavioural mux4_1 pairing
// check, and an asynchronous mid-stream reset.
module tb_rr_mux_sel;

  logic       clk_i;
  logic       rst_ni;
  logic [1:0] data0_i, data1_i, data2_i, data3_i;
  logic [3:0] valid_i;
  logic [3:0] ready_o;
  logic [1:0] data_o;
  logic [1:0] direction_o;
  logic       valid_o;
  logic       ready_i;

  int checks;
  int errors;

  rr_mux_sel #(.DATA_W(2)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .data0_i     (data0_i),
    .data1_i     (data1_i),
    .data2_i     (data2_i),
    .data3_i     (data3_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_o      (data_o),
    .direction_o (direction_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] valid;
    logic       rdy;
    logic [3:0] exp_ready;
    logic       exp_valid;
    logic [1:0] exp_data;
    logic [1:0] exp_dir;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural mux4_1 steered by direction_o.
  function automatic logic [1:0] mux4(input logic [1:0] dir);
    case (dir)
      2'd0:    return data0_i;
      2'd1:    return data1_i;
      2'd2:    return data2_i;
      default: return data3_i;
    endcase
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    //          valid    rdy   ready    v     data   dir
    vecs[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'b11, 2'd2};
    vecs[1]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'b00, 2'd3};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'b01, 2'd0};
    vecs[3]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'b10, 2'd1};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'b11, 2'd2};
    vecs[5]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'b00, 2'd3};
    vecs[6]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'b01, 2'd0};
    vecs[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'b01, 2'd0};
    vecs[8]  = '{4'b1010, 1'b0, 4'b0010, 1'b1, 2'b10, 2'd1};
    vecs[9]  = '{4'b1010, 1'b0, 4'b0000, 1'b1, 2'b10, 2'd1};
    vecs[10] = '{4'b1010, 1'b0, 4'b0000, 1'b1, 2'b10, 2'd1};
    vecs[11] = '{4'b1010, 1'b0, 4'b0000, 1'b1, 2'b10, 2'd1};
    vecs[12] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'b00, 2'd3};
    vecs[13] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'b10, 2'd1};
    vecs[14] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'b01, 2'd0};
    vecs[15] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'b01, 2'd0};
    vecs[16] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'b01, 2'd0};
    vecs[17] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'b01, 2'd0};

    data0_i = 2'b01;
    data1_i = 2'b10;
    data2_i = 2'b11;
    data3_i = 2'b00;
    valid_i = 4'b1111;
    ready_i = 1'b1;
    rst_ni  = 1'b0;

    // Reset with all channels requesting.
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_ready_o",   32'(ready_o),     32'h0);
    chk("rst_valid_o",   32'(valid_o),     32'h0);
    chk("rst_data_o",    32'(data_o),      32'h0);
    chk("rst_direction", 32'(direction_o), 32'h0);

    // Release: first grant goes to ch0.
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("rel_first_grant", 32'(ready_o), 32'h1);

    // Vector table; inputs change mid-low-phase, outputs sampled after edge.
    for (int i = 0; i < 18; i++) begin
      valid_i = vecs[i].valid;
      ready_i = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_ready_o", i), 32'(ready_o), 32'(vecs[i].exp_ready));
      @(posedge clk_i);
      #1;
      chk($sformatf("v%0d_valid_o", i), 32'(valid_o),     32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_data_o", i),  32'(data_o),      32'(vecs[i].exp_data));
      chk($sformatf("v%0d_dir_o", i),   32'(direction_o), 32'(vecs[i].exp_dir));
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_mux_pair", i), 32'(mux4(direction_o)), 32'(vecs[i].exp_data));
      end
      @(negedge clk_i);
    end

    // Mid-stream reset: load a word, then drop rst_ni between edges.
    valid_i = 4'b0010;
    ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("mid_loaded", 32'(valid_o), 32'h1);
    valid_i = 4'b0000;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid_o", 32'(valid_o),     32'h0);
    chk("mid_rst_data_o",  32'(data_o),      32'h0);
    chk("mid_rst_dir_o",   32'(direction_o), 32'h0);
    chk("mid_rst_ready_o", 32'(ready_o),     32'h0);

    @(negedge clk_i);
    data3_i = 2'b10;
    valid_i = 4'b1000;
    ready_i = 1'b1;
    rst_ni  = 1'b1;
    #1;
    chk("post_rst_ready_o", 32'(ready_o), 32'h8);
    @(posedge clk_i);
    #1;
    chk("post_rst_valid_o", 32'(valid_o),     32'h1);
    chk("post_rst_dir_o",   32'(direction_o), 32'h3);
    chk("post_rst_data_o",  32'(data_o),      32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
